// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Combines load-use, MEM-stage redirect and dmem-wait conditions into
// per-stage enable/flush controls. It also keeps saturating stall and
// flush counters and a sticky dmem timeout flag.
// Priority is memory wait > redirect > load-use.
module pipe_hazard_ctrl #(
  parameter int REDIRECT_CYC = 0,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             mem_pcsel,
  input  logic             mem_dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    REDIRECT  = 2'd2
  } state_t;

  localparam int RC_W = (REDIRECT_CYC < 2) ? 1 : $clog2(REDIRECT_CYC + 1);
  localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(REDIRECT_CYC);
  localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
  localparam logic [RC_W-1:0]  RC_ZERO = '0;
  localparam logic [15:0]      TO_VAL  = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t          cur_state, nxt_state;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [15:0]     wait_q, wait_d;
  logic            timeout_d;
  logic            lu, mw;

  // Hazard detection: x0 never creates a dependency.
  assign lu = ex_is_load && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (ex_rd == id_rs1)) ||
               (id_use_rs2 && (ex_rd == id_rs2)));
  assign mw = mem_dmem_req && !dmem_ready;

  assign state = cur_state;

  // Next-state, counter updates and stage controls.
  // A stage register takes new data only when its enable is 1.
  // When its flush is 1, it loads a NOP instead of the stage data.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    nxt_state   = cur_state;
    rc_d        = rc_q;
    wait_d      = wait_q;
    if (mw) begin
      // Freeze everything up to MEM and bubble into WB.
      // The redirect countdown is preserved so it can resume later.
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_flush = 1'b1;
      nxt_state = DMEM_WAIT;
      if (wait_q != TO_VAL) wait_d = wait_q + 16'd1;
    end else begin
      if (cur_state == DMEM_WAIT) begin
        wait_d    = 16'd0;
        nxt_state = (rc_q != RC_ZERO) ? REDIRECT : RUN;
      end
      if (cur_state == REDIRECT) begin
        ifid_flush = 1'b1;
        if (rc_q != RC_ZERO) rc_d = rc_q - RC_ONE;
        if (rc_q <= RC_ONE) nxt_state = RUN;
      end
      if (mem_pcsel) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        if (REDIRECT_CYC > 0) begin
          nxt_state = REDIRECT;
          rc_d      = RC_LOAD;
        end else begin
          nxt_state = RUN;
        end
      end else if (lu && (cur_state != REDIRECT)) begin
        // Hold IF and ID for one cycle and bubble into EX.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
    timeout_d = dmem_timeout || (mw && (wait_d == TO_VAL));
  end

  // State, counters and sticky flag; all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state    <= RUN;
      rc_q         <= '0;
      wait_q       <= '0;
      dmem_timeout <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      cur_state    <= nxt_state;
      rc_q         <= rc_d;
      wait_q       <= wait_d;
      dmem_timeout <= timeout_d;
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (mem_pcsel && !mw && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Generates per-stage enable and flush controls from three sources:
  - load-use hazards between ID and EX;
  - taken branch/jump redirects resolved in MEM;
  - data-memory wait handshakes from the MEM stage.
- Keeps saturating stall and flush performance counters and a sticky dmem timeout flag.
- Sits beside the control decoder; its outputs gate the pipeline registers and the PC register.

Parameters:
- REDIRECT_CYC, 0: extra fetch-bubble cycles inserted after a redirect (covers imem latency); 0 = no REDIRECT state.
- TIMEOUT, 255: consecutive dmem wait cycles before dmem_timeout sets; range 1..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2 (set for R, S and B types).
- ex_rd  in  5  rd of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load (WB select = dmem, write enable = 1).
- mem_pcsel  in  1  taken branch/jal/jalr in MEM.
- mem_dmem_req  in  1  MEM instruction is a load or store.
- dmem_ready  in  1  dmem completes the MEM access this cycle.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP (0x00000013).
- idex_en  out  1  ID/EX register enable.
- idex_flush  out  1  ID/EX loads a NOP.
- exmem_en  out  1  EX/MEM register enable.
- exmem_flush  out  1  EX/MEM loads a NOP.
- memwb_flush  out  1  MEM/WB loads a NOP.
- dmem_timeout  out  1  sticky timeout error.
- stall_cnt  out  CNT_W  cycles with pc_en=0 (saturating).
- flush_cnt  out  CNT_W  redirect events (saturating).
- state  out  2  FSM state: 0 RUN, 1 DMEM_WAIT, 2 REDIRECT.

Behaviour:
- Reset (rst_n=0, async):
  - state = RUN; wait counter, redirect counter, stall_cnt, flush_cnt and dmem_timeout all cleared.
- Enable outputs are combinational from state and inputs. Counters and state update on posedge clk.
- Defaults: all enables = 1, all flushes = 0.
- Load-use hazard (lu):
  - lu = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
- Memory wait (mw) = mem_dmem_req & ~dmem_ready.
- Priority: mw > mem_pcsel > lu.
- mw (any state):
  - pc_en = ifid_en = idex_en = exmem_en = 0; memwb_flush = 1.
  - Next state = DMEM_WAIT.
  - A simultaneous mem_pcsel is ignored that cycle; it is honoured on the cycle dmem_ready rises.
- mem_pcsel, no mw:
  - ifid_flush = idex_flush = exmem_flush = 1; pc_en = 1 (PC takes the target); lu is suppressed.
  - flush_cnt increments.
  - If REDIRECT_CYC > 0: next state = REDIRECT, redirect counter loaded with REDIRECT_CYC. Otherwise stay in / return to RUN.
- lu, no mw, no mem_pcsel:
  - pc_en = ifid_en = 0; idex_flush = 1. EX, MEM and WB advance.
  - Lasts exactly 1 cycle, because the load moves to MEM and lu drops.
- REDIRECT:
  - ifid_flush = 1 and pc_en = 1 each cycle; redirect counter decrements.
  - Returns to RUN when the counter reaches 1 at the clock edge.
  - Decode-side signals are meaningless here, so lu is ignored.
  - A new mem_pcsel reloads the counter; mw preempts to DMEM_WAIT, and REDIRECT resumes afterwards with its counter preserved.
- DMEM_WAIT:
  - Wait counter increments each mw cycle and saturates at TIMEOUT.
  - On reaching TIMEOUT, dmem_timeout sets and stays set until reset. The pipeline keeps waiting; no abort.
  - When dmem_ready=1: wait counter clears, and next state = REDIRECT if the redirect counter is nonzero, else RUN. Normal rules apply in that same cycle.
- stall_cnt increments on every cycle where pc_en=0. Both counters hold at all-ones.
- x0 is never a hazard source.

Test Plan:
- Load-use: lw x5 in EX (ex_is_load=1, ex_rd=5), add using id_rs2=5 with id_use_rs2=1 → exactly 1 cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1; next cycle all enables=1.
- x0 / no-use: ex_rd=0 with id_rs1=0, then ex_rd=5 with id_rs2=5 but id_use_rs2=0 (I-type) → no stall in either case; stall_cnt stays 0.
- Redirect with load-use conflict: mem_pcsel=1 together with lu=1, REDIRECT_CYC=2 → ifid/idex/exmem flush=1 and pc_en=1; state=REDIRECT for 2 cycles with ifid_flush=1; then RUN; flush_cnt=1.
- Dmem wait: mem_dmem_req=1 with dmem_ready=0 for 4 cycles, then 1 → state=DMEM_WAIT, all enables=0 and memwb_flush=1 for 4 cycles; stall_cnt=4; RUN on the ready cycle.
- Timeout: TIMEOUT=3, dmem_ready held 0 for 5 cycles → dmem_timeout=1 after the 3rd wait cycle; it stays 1 after ready; it clears only on rst_n=0.
- Async reset mid-wait: drop rst_n in DMEM_WAIT without a clock edge → state=0, counters=0, outputs at defaults immediately.
